rs_alu: RTL

- Reservation station directly upstream of the combinational integer ALU.
- Buffers issued ALU and branch micro-ops and captures operand values from the common data bus (CDB).
- Each cycle, selects one entry with both operands ready and drives the ALU inputs from a register stage.
- The ALU treats alu_op == 0 as "no operation / result invalid", so this block drives 0 whenever nothing is dispatched.

---
 rtl/rs_alu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with CDB wakeup and registered dispatch; define RS_OLDEST_FIRST_EN for oldest-ready select
module rs_alu #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W = 5,
  parameter int OP_W = 7
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_vi,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qi_valid,
  input  logic             issue_qj_valid,
  input  logic [TAG_W-1:0] issue_qi,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [31:0]      issue_imm,
  input  logic [TAG_W-1:0] issue_rob,
  input  logic [31:0]      issue_pc,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             flush,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rd
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy, qi_valid, qj_valid, ready;
  logic [OP_W-1:0] op [RS_SIZE];
  logic [31:0] vi [RS_SIZE];
  logic [31:0] vj [RS_SIZE];
  logic [31:0] imm [RS_SIZE];
  logic [31:0] pc [RS_SIZE];
  logic [TAG_W-1:0] qi [RS_SIZE];
  logic [TAG_W-1:0] qj [RS_SIZE];
  logic [TAG_W-1:0] rob [RS_SIZE];
  logic [IW-1:0] win, slot;
  logic found, hit_i, hit_j, accept;
  assign ready = busy & ~qi_valid & ~qj_valid;
  assign full = &busy;
  assign accept = issue_valid && !full;
  // an operand produced on the CDB in the issue cycle is captured directly
  assign hit_i = cdb_valid && issue_qi_valid && cdb_tag == issue_qi;
  assign hit_j = cdb_valid && issue_qj_valid && cdb_tag == issue_qj;
  always_comb begin
    slot = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy[i]) slot = IW'(i);
  end
`ifdef RS_OLDEST_FIRST_EN
  logic [IW-1:0] age [RS_SIZE];
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (ready[i] && (!found || age[i] > age[win])) begin
        found = 1'b1;
        win = IW'(i);
      end
  end
  always_ff @(posedge clk_in)
    if (!rst_in && rdy_in && !flush && accept)
      for (int i = 0; i < RS_SIZE; i++)
        age[i] <= IW'(i) == slot ? '0 : (busy[i] && ~&age[i]) ? age[i] + 1'b1 : age[i];
`else
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (ready[i]) begin
        found = 1'b1;
        win = IW'(i);
      end
  end
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      alu_op <= '0;
      alu_vi <= '0;
      alu_vj <= '0;
      alu_imm <= '0;
      alu_pc <= '0;
      alu_rd <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy <= '0;
        alu_op <= '0;
      end else begin
        alu_op <= found ? op[win] : '0;
        if (found) begin
          alu_vi <= vi[win];
          alu_vj <= vj[win];
          alu_imm <= imm[win];
          alu_pc <= pc[win];
          alu_rd <= rob[win];
          busy[win] <= 1'b0;
        end
        for (int i = 0; i < RS_SIZE; i++)
          if (busy[i] && cdb_valid) begin
            if (qi_valid[i] && qi[i] == cdb_tag) begin
              qi_valid[i] <= 1'b0;
              vi[i] <= cdb_value;
            end
            if (qj_valid[i] && qj[i] == cdb_tag) begin
              qj_valid[i] <= 1'b0;
              vj[i] <= cdb_value;
            end
          end
        if (accept) begin
          busy[slot] <= 1'b1;
          op[slot] <= issue_op;
          vi[slot] <= hit_i ? cdb_value : issue_vi;
          vj[slot] <= hit_j ? cdb_value : issue_vj;
          qi_valid[slot] <= issue_qi_valid && !hit_i;
          qj_valid[slot] <= issue_qj_valid && !hit_j;
          qi[slot] <= issue_qi;
          qj[slot] <= issue_qj;
          imm[slot] <= issue_imm;
          pc[slot] <= issue_pc;
          rob[slot] <= issue_rob;
        end
      end
    end
  end
endmodule
